// File: rtl/teclado_cajero.sv
// teclado_cajero: keypad front-end for the ATM controller.
// Debounces the raw keypad code and emits one event per physical press.
// In PIN mode, digits are forwarded to the controller. In amount mode,
// digits are accumulated into a binary amount that ENTER commits.
// Ports:
//   CLK          system clock, all logic on posedge
//   RESET        synchronous active-low reset
//   TECLA_VALIDA raw level, high while any key is held
//   TECLA        raw key code (0-9 digit, A ENTER, B BORRAR, C RETIRO, D DEPOSITO)
//   MODO_MONTO   0 = PIN mode, 1 = amount mode
//   DIGITO/DIGITO_STB   forwarded digit and its strobe
//   TIPO_TRANS/TIPO_STB transaction type (1 retiro, 0 deposito) and strobe
//   MONTO/MONTO_STB     committed amount and its strobe
//   ERROR_TECLA         pulse on a rejected key
module teclado_cajero #(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned MAX_DIG      = 9
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TECLA_VALIDA,
    input  logic [3:0]  TECLA,
    input  logic        MODO_MONTO,
    output logic [3:0]  DIGITO,
    output logic        DIGITO_STB,
    output logic        TIPO_TRANS,
    output logic        TIPO_STB,
    output logic [31:0] MONTO,
    output logic        MONTO_STB,
    output logic        ERROR_TECLA
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned DW = $clog2(MAX_DIG + 1);
    localparam int unsigned AW = 32;

    localparam logic [3:0] K_ENTER    = 4'hA;
    localparam logic [3:0] K_BORRAR   = 4'hB;
    localparam logic [3:0] K_RETIRO   = 4'hC;
    localparam logic [3:0] K_DEPOSITO = 4'hD;

    typedef enum logic [1:0] {
        LIBRE      = 2'd0,
        FILTRO     = 2'd1,
        PRESIONADA = 2'd2,
        SOLTANDO   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          ev_c;

    logic          mode_q;
    logic [AW-1:0] acc_q, acc_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    logic [3:0]    digito_d;
    logic          digito_stb_d;
    logic          tipo_d;
    logic          tipo_stb_d;
    logic [AW-1:0] monto_d;
    logic          monto_stb_d;
    logic          error_d;

    // Debounce state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= LIBRE;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Debounce next state; ev_c fires on the last stable sample of a press
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ev_c    = 1'b0;
        case (state_q)
            LIBRE: begin
                if (TECLA_VALIDA) begin
                    code_d  = TECLA;
                    cnt_d   = CW'(1);
                    state_d = FILTRO;
                end
            end
            FILTRO: begin
                if (!TECLA_VALIDA) begin
                    state_d = LIBRE;
                end else if (TECLA != code_q) begin
                    code_d = TECLA;
                    cnt_d  = CW'(1);
                end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                    cnt_d   = CW'(DEBOUNCE_CYC);
                    state_d = PRESIONADA;
                    ev_c    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESIONADA: begin
                if (!TECLA_VALIDA) begin
                    cnt_d   = CW'(1);
                    state_d = SOLTANDO;
                end
            end
            SOLTANDO: begin
                if (TECLA_VALIDA) begin
                    state_d = PRESIONADA;
                end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = LIBRE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = LIBRE;
        endcase
    end

    // Event decode; a mode edge clears the accumulator before the event applies
    always_comb begin
        logic          mode_edge;
        logic [AW-1:0] acc_base;
        logic [DW-1:0] dcnt_base;

        mode_edge    = (MODO_MONTO != mode_q);
        acc_base     = mode_edge ? '0 : acc_q;
        dcnt_base    = mode_edge ? '0 : dcnt_q;

        acc_d        = acc_base;
        dcnt_d       = dcnt_base;
        digito_d     = DIGITO;
        digito_stb_d = 1'b0;
        tipo_d       = TIPO_TRANS;
        tipo_stb_d   = 1'b0;
        monto_d      = MONTO;
        monto_stb_d  = 1'b0;
        error_d      = 1'b0;

        if (ev_c) begin
            if (code_q <= 4'd9) begin
                if (!MODO_MONTO) begin
                    digito_d     = code_q;
                    digito_stb_d = 1'b1;
                end else if (dcnt_base < DW'(MAX_DIG)) begin
                    // acc*10 + digit without a multiplier
                    acc_d  = (acc_base << 3) + (acc_base << 1) + AW'(code_q);
                    dcnt_d = dcnt_base + DW'(1);
                end else begin
                    error_d = 1'b1;
                end
            end else begin
                case (code_q)
                    K_ENTER: begin
                        if (MODO_MONTO) begin
                            if (dcnt_base != '0) begin
                                monto_d     = acc_base;
                                monto_stb_d = 1'b1;
                                acc_d       = '0;
                                dcnt_d      = '0;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end
                    K_BORRAR: begin
                        acc_d  = '0;
                        dcnt_d = '0;
                    end
                    K_RETIRO: begin
                        tipo_d     = 1'b1;
                        tipo_stb_d = 1'b1;
                    end
                    K_DEPOSITO: begin
                        tipo_d     = 1'b0;
                        tipo_stb_d = 1'b1;
                    end
                    default: error_d = 1'b1;
                endcase
            end
        end
    end

    // Accumulator and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mode_q      <= 1'b0;
            acc_q       <= '0;
            dcnt_q      <= '0;
            DIGITO      <= '0;
            DIGITO_STB  <= 1'b0;
            TIPO_TRANS  <= 1'b0;
            TIPO_STB    <= 1'b0;
            MONTO       <= '0;
            MONTO_STB   <= 1'b0;
            ERROR_TECLA <= 1'b0;
        end else begin
            mode_q      <= MODO_MONTO;
            acc_q       <= acc_d;
            dcnt_q      <= dcnt_d;
            DIGITO      <= digito_d;
            DIGITO_STB  <= digito_stb_d;
            TIPO_TRANS  <= tipo_d;
            TIPO_STB    <= tipo_stb_d;
            MONTO       <= monto_d;
            MONTO_STB   <= monto_stb_d;
            ERROR_TECLA <= error_d;
        end
    end

endmodule

// File: tb/tb_teclado_cajero.sv
// Scoreboard bench for teclado_cajero: stimulus pushes expected strobes
// computed from a behavioural model; a negedge monitor pops and compares.
module tb_teclado_cajero;

    localparam int unsigned N    = 4;
    localparam int unsigned MAXD = 9;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        TECLA_VALIDA = 1'b0;
    logic [3:0]  TECLA = 4'h0;
    logic        MODO_MONTO = 1'b0;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        TIPO_TRANS;
    logic        TIPO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        ERROR_TECLA;

    teclado_cajero #(.DEBOUNCE_CYC(N), .MAX_DIG(MAXD)) dut (
        .CLK(CLK), .RESET(RESET), .TECLA_VALIDA(TECLA_VALIDA), .TECLA(TECLA),
        .MODO_MONTO(MODO_MONTO), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
        .TIPO_TRANS(TIPO_TRANS), .TIPO_STB(TIPO_STB), .MONTO(MONTO),
        .MONTO_STB(MONTO_STB), .ERROR_TECLA(ERROR_TECLA)
    );

    always #5 CLK = ~CLK;

    // kind: 0 digit, 1 amount, 2 type, 3 error
    typedef struct {
        int          kind;
        int          cyc;
        logic [3:0]  dig;
        logic [31:0] mon;
        logic        tip;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model state
    longint      m_acc = 0;
    int          m_dc = 0;
    logic [3:0]  m_dig = 4'h0;
    logic [31:0] m_mon = 32'h0;
    logic        m_tip = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c0);
        exp_t e;
        e.kind = kind;
        e.cyc  = c0 + int'(N);
        e.dig  = m_dig;
        e.mon  = m_mon;
        e.tip  = m_tip;
        sbq.push_back(e);
    endtask

    // Keypad semantics applied to one accepted press
    task automatic model_event(input int k, input int c0);
        if (k <= 9) begin
            if (!MODO_MONTO) begin
                m_dig = 4'(k);
                push(0, c0);
            end else if (m_dc < int'(MAXD)) begin
                m_acc = m_acc * 10 + k;
                m_dc++;
            end else begin
                push(3, c0);
            end
        end else if (k == 10) begin
            if (MODO_MONTO) begin
                if (m_dc > 0) begin
                    m_mon = 32'(m_acc);
                    m_acc = 0;
                    m_dc  = 0;
                    push(1, c0);
                end else begin
                    push(3, c0);
                end
            end
        end else if (k == 11) begin
            m_acc = 0;
            m_dc  = 0;
        end else if (k == 12) begin
            m_tip = 1'b1;
            push(2, c0);
        end else if (k == 13) begin
            m_tip = 1'b0;
            push(2, c0);
        end else begin
            push(3, c0);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        TECLA_VALIDA = 1'b0;
        repeat (n) tick();
    endtask

    task automatic press(input int k, input int hold, input int rel);
        int c0;
        c0 = cyc;
        if (hold >= int'(N)) model_event(k, c0);
        TECLA = 4'(k);
        TECLA_VALIDA = 1'b1;
        repeat (hold) tick();
        idle(rel);
    endtask

    task automatic key(input int k);
        press(k, N + 2, N + 2);
    endtask

    task automatic set_mode(input logic m);
        if (m != MODO_MONTO) begin
            m_acc = 0;
            m_dc  = 0;
        end
        MODO_MONTO = m;
        idle(2);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_digito"}, DIGITO, 0);
        check({tag, "_digito_stb"}, DIGITO_STB, 0);
        check({tag, "_tipo"}, TIPO_TRANS, 0);
        check({tag, "_tipo_stb"}, TIPO_STB, 0);
        check({tag, "_monto"}, MONTO, 0);
        check({tag, "_monto_stb"}, MONTO_STB, 0);
        check({tag, "_error"}, ERROR_TECLA, 0);
    endtask

    // Monitor: compare every strobe against the head of the scoreboard
    always @(negedge CLK) begin
        int   ns;
        int   kind;
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            check("missing_strobe", cyc, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        ns = int'(DIGITO_STB) + int'(MONTO_STB) + int'(TIPO_STB) + int'(ERROR_TECLA);
        if (ns > 1) begin
            check("exclusive_strobes", ns, 1);
        end else if (ns == 1) begin
            if (sbq.size() == 0) begin
                check("unexpected_strobe_cycle", cyc, -1);
            end else begin
                e = sbq.pop_front();
                kind = DIGITO_STB ? 0 : MONTO_STB ? 1 : TIPO_STB ? 2 : 3;
                check("strobe_kind", kind, e.kind);
                check("strobe_cycle", cyc, e.cyc);
                check("digito", DIGITO, e.dig);
                check("monto", MONTO, e.mon);
                check("tipo_trans", TIPO_TRANS, e.tip);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        int k;
        RESET = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        RESET = 1'b1;
        idle(3);

        // PIN digits with fixed timing
        key(7); key(3); key(9); key(1);

        // Glitches shorter than the filter, then one long hold
        press(5, 2, 3);
        press(5, 3, 3);
        press(5, 20, N + 2);

        // Code change inside the filter restarts the count
        TECLA = 4'd5;
        TECLA_VALIDA = 1'b1;
        tick(); tick();
        c0 = cyc;
        model_event(6, c0);
        TECLA = 4'd6;
        repeat (N + 2) tick();
        idle(N + 2);

        // Release bounce returns to the held state, no second event
        c0 = cyc;
        model_event(8, c0);
        TECLA = 4'd8;
        TECLA_VALIDA = 1'b1;
        repeat (6) tick();
        TECLA_VALIDA = 1'b0;
        repeat (2) tick();
        TECLA_VALIDA = 1'b1;
        tick();
        idle(N + 4);

        // Amount entry, then ENTER with no digits
        set_mode(1'b1);
        key(1); key(2); key(5); key(0); key(10);
        key(10);

        // Digit limit
        for (int i = 0; i < 10; i++) key(9);
        key(10);

        // BORRAR and transaction keys
        key(4); key(2); key(11); key(8); key(10);
        key(12); key(13); key(14);

        // Reset mid-entry and mid-filter
        key(12);
        key(3); key(3);
        TECLA = 4'd4;
        TECLA_VALIDA = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        tick();
        m_acc = 0; m_dc = 0; m_dig = 4'h0; m_mon = 32'h0; m_tip = 1'b0;
        check_zero_outputs("midreset");
        RESET = 1'b1;
        idle(N + 2);
        key(6); key(10);

        // Randomised presses across both modes
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) set_mode(~MODO_MONTO);
            if ($urandom_range(0, 2) != 0) k = int'($urandom_range(0, 9));
            else k = int'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0)
                press(k, int'($urandom_range(1, N - 1)), int'($urandom_range(1, 3)));
            else
                press(k, int'($urandom_range(N, N + 5)), int'($urandom_range(N + 1, N + 4)));
        end
        set_mode(1'b1);
        key(4); key(2); key(10);

        idle(N + 4);
        check("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
